nf10_id_rom_arbiter: RTL and testbench
======================================

Name: nf10_id_rom_arbiter

Overview:
Shares the single-port 16x32 identifier ROM between C_NUM_REQ independent read requesters, for example the AXI-Lite IPIF read path and a local boot/self-describe engine.
- Grants one requester at a time in round-robin order.
- Drives the ROM enable and address, waits out the ROM read latency, registers the word and returns it with a one-cycle ack.
- Sits between the IPIF-side logic and id_rom16x32.

Parameters:
C_NUM_REQ, 2, number of requesters (2..8)
C_ADDR_WIDTH, 4, ROM word-address width
C_DATA_WIDTH, 32, ROM word width
C_ROM_LATENCY, 1, cycles from rom_en to valid rom_data (1..3)

Ports:
S_AXI_ACLK  in  1  clock; all logic on rising edge
S_AXI_ARESETN  in  1  asynchronous active-low reset
req  in  C_NUM_REQ  per-requester read request, level, held until ack
req_addr  in  C_NUM_REQ*C_ADDR_WIDTH  flattened word addresses; slice i belongs to req[i]
ack  out  C_NUM_REQ  one-cycle read-done pulse, one-hot
rdata  out  C_DATA_WIDTH  registered read word, valid in the ack cycle and held until the next capture
busy  out  1  high whenever state is not IDLE
rom_en  out  1  ROM read enable
rom_addr  out  C_ADDR_WIDTH  ROM address
rom_data  in  C_DATA_WIDTH  ROM output

Behaviour:
- Reset (asynchronous, on ARESETN low):
  - State goes to IDLE.
  - ack, rom_en, rom_addr, rdata and busy all clear to 0.
  - Round-robin pointer set so req[0] has highest priority.
- FSM states: IDLE, ISSUE, WAIT, ACK, RELEASE.
- IDLE:
  - If any req bit is set, pick the winner: the first set bit at or after the pointer, wrapping modulo C_NUM_REQ.
  - Register the grant index and that requester's address, then go to ISSUE.
  - If no req bit is set, stay in IDLE.
- ISSUE:
  - rom_en=1 and rom_addr=latched address for exactly one cycle.
  - Load the latency counter with C_ROM_LATENCY-1, then go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter reaches 0, capture rom_data into rdata and go to ACK.
  - Net effect: rdata is sampled exactly C_ROM_LATENCY cycles after the rom_en cycle.
- ACK:
  - ack[grant]=1 for one cycle, only if req[grant] is still high. Otherwise ack stays 0 (abort case).
  - Pointer moves to grant+1, wrapping at C_NUM_REQ.
  - Next state is RELEASE.
- RELEASE:
  - One dead cycle; all req bits are ignored, so a requester that is still dropping req after ack is not re-served.
  - Next state is IDLE.
- Latency: req sampled in IDLE at cycle t, rom_en at t+1, ack at t+2+C_ROM_LATENCY. Next grant can be sampled at t+4+C_ROM_LATENCY. With C_ROM_LATENCY=1: ack at t+3, 5-cycle service period.
- Simultaneous requests: exactly one is granted per service. Losers keep req asserted and are served in rotation. No requester waits more than C_NUM_REQ-1 services.
- Abort: if req[grant] drops before ACK, the transaction still runs to completion with ack suppressed. rdata is still updated. The pointer still advances.
- New req asserted during ISSUE/WAIT/ACK/RELEASE: held off with no effect, and is seen in the next IDLE.
- Changes to req_addr after grant: ignored; the address is latched in IDLE.
- rom_en is never high outside ISSUE. ack is never more than one bit, never more than one cycle.
- Reset mid-transaction: immediate return to reset values; the in-flight read is dropped with no ack.

Decomposition:
- Package nf10_id_rom_arb_pkg:
  - FSM state encoding localparams: IDLE=0, ISSUE=1, WAIT=2, ACK=3, RELEASE=4, 3-bit.
  - clog2 function for grant-index and counter widths.
- Sub-module nf10_rr_pick: combinational round-robin winner.
  - Inputs: req vector, pointer.
  - Outputs: winner index, any_valid.
  - Reusable by other NetFPGA register-space arbiters.

Test Plan:
1. Single request: req=2'b01, req_addr[0]=4'h3, ROM word3=32'hDEADBEEF, C_ROM_LATENCY=1 -> rom_en with rom_addr=3 at t+1; ack=2'b01 and rdata=32'hDEADBEEF at t+3; busy high t+1..t+4.
2. Simultaneous: req=2'b11, addr0=0, addr1=5, each requester drops req the cycle after its ack -> requester 0 acked first with word0, then requester 1 with word5; acks 5 cycles apart.
3. Fairness: req=2'b11 held continuously for 8 services -> ack alternates 01,10,01,10…; never the same requester twice in a row.
4. Abort: req[0] dropped during WAIT -> no ack pulse; rdata updated; next IDLE grants req[1] first, since the pointer advanced.
5. Latency sweep: C_ROM_LATENCY=3 with a ROM model delayed 3 cycles -> ack at t+5 and correct word; rom_en is a single-cycle pulse.
6. Reset in WAIT: ARESETN pulsed low -> ack, rom_en and busy drop immediately; after release, req=2'b10 is granted with pointer reset behaviour (req[0] priority if both set).

Source files
------------

// File: rtl/nf10_id_rom_arbiter_pkg.sv
// nf10_id_rom_arb_pkg
//   Shared definitions for the identifier-ROM arbiter: FSM state encoding
//   and a clog2 helper used to size the grant index and latency counter.
package nf10_id_rom_arb_pkg;

    localparam int ST_W = 3;

    typedef enum logic [ST_W-1:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT    = 3'd2,
        ACK     = 3'd3,
        RELEASE = 3'd4
    } state_e;

    // Ceiling log2, never less than 1 so that single-entry ranges still get
    // a real (one-bit) vector.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/nf10_id_rom_arbiter_if.sv
// nf10_id_rom_arbiter_if
//   Bundles the requester side and the ROM side of the arbiter.
//   slave  : the arbiter (consumes req/req_addr/rom_data, drives the rest)
//   master : whoever surrounds it -- the requesters plus the ROM itself
//   Signals:
//     req       per-requester level request, held until ack
//     req_addr  flattened word addresses, slice i belongs to req[i]
//     ack       one-cycle one-hot read-done pulse
//     rdata     registered read word, valid from the ack cycle onward
//     busy      arbiter is not idle
//     rom_en    ROM read enable
//     rom_addr  ROM word address
//     rom_data  ROM output word
interface nf10_id_rom_arbiter_if #(
    parameter int C_NUM_REQ    = 2,
    parameter int C_ADDR_WIDTH = 4,
    parameter int C_DATA_WIDTH = 32
);
    logic [C_NUM_REQ-1:0]              req;
    logic [C_NUM_REQ*C_ADDR_WIDTH-1:0] req_addr;
    logic [C_NUM_REQ-1:0]              ack;
    logic [C_DATA_WIDTH-1:0]           rdata;
    logic                              busy;
    logic                              rom_en;
    logic [C_ADDR_WIDTH-1:0]           rom_addr;
    logic [C_DATA_WIDTH-1:0]           rom_data;

    modport slave (
        input  req, req_addr, rom_data,
        output ack, rdata, busy, rom_en, rom_addr
    );

    modport master (
        output req, req_addr, rom_data,
        input  ack, rdata, busy, rom_en, rom_addr
    );
endinterface

// File: rtl/nf10_rr_pick.sv
// nf10_rr_pick
//   Combinational round-robin winner select: the first set bit of req at or
//   after ptr, wrapping modulo N.
//   Ports:
//     req        request vector
//     ptr        highest-priority index
//     winner     selected index (0 when nothing is requested)
//     any_valid  at least one request bit is set
module nf10_rr_pick #(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] winner,
    output logic         any_valid
);

    logic found;
    int   idx;

    always_comb begin
        winner    = '0;
        any_valid = |req;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!found && req[idx]) begin
                winner = W'(idx);
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/nf10_id_rom_arbiter.sv
// nf10_id_rom_arbiter
//   Shares the single-port identifier ROM between C_NUM_REQ read
//   requesters. One requester is granted per service in round-robin order;
//   the arbiter issues a one-cycle ROM read, waits out C_ROM_LATENCY,
//   registers the word and pulses ack to the granted requester.
//   Ports:
//     S_AXI_ACLK     clock, rising edge
//     S_AXI_ARESETN  asynchronous active-low reset
//     bus            requester + ROM signals (slave side)
module nf10_id_rom_arbiter
    import nf10_id_rom_arb_pkg::*;
#(
    parameter int C_NUM_REQ     = 2,
    parameter int C_ADDR_WIDTH  = 4,
    parameter int C_DATA_WIDTH  = 32,
    parameter int C_ROM_LATENCY = 1
) (
    input  logic                  S_AXI_ACLK,
    input  logic                  S_AXI_ARESETN,
    nf10_id_rom_arbiter_if.slave  bus
);

    localparam int GW = clog2(C_NUM_REQ);
    localparam int CW = clog2(C_ROM_LATENCY);

    state_e                  state, state_nxt;
    logic [GW-1:0]           ptr;
    logic [GW-1:0]           grant;
    logic [GW-1:0]           pick_idx;
    logic                    pick_vld;
    logic [C_ADDR_WIDTH-1:0] addr_q;
    logic [CW-1:0]           cnt;
    logic [C_DATA_WIDTH-1:0] rdata_q;

    nf10_rr_pick #(
        .N (C_NUM_REQ),
        .W (GW)
    ) u_pick (
        .req       (bus.req),
        .ptr       (ptr),
        .winner    (pick_idx),
        .any_valid (pick_vld)
    );

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) state <= IDLE;
        else                state <= state_nxt;
    end

    // Next state and outputs. ack looks at the live req so a requester that
    // gave up before the ACK cycle gets no pulse (abort).
    always_comb begin
        state_nxt    = state;
        bus.busy     = (state != IDLE);
        bus.rom_en   = 1'b0;
        bus.rom_addr = '0;
        bus.ack      = '0;
        bus.rdata    = rdata_q;
        case (state)
            IDLE: begin
                if (pick_vld) state_nxt = ISSUE;
            end
            ISSUE: begin
                bus.rom_en   = 1'b1;
                bus.rom_addr = addr_q;
                state_nxt    = WAIT;
            end
            WAIT: begin
                if (cnt == '0) state_nxt = ACK;
            end
            ACK: begin
                if (bus.req[grant]) bus.ack[grant] = 1'b1;
                state_nxt = RELEASE;
            end
            RELEASE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath. The counter is loaded with latency-1 in ISSUE so that the
    // WAIT cycle in which it reads 0 is exactly C_ROM_LATENCY cycles after
    // the rom_en cycle; rom_data is captured on that cycle's edge.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            ptr     <= '0;
            grant   <= '0;
            addr_q  <= '0;
            cnt     <= '0;
            rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        grant  <= pick_idx;
                        addr_q <= bus.req_addr[int'(pick_idx)*C_ADDR_WIDTH +: C_ADDR_WIDTH];
                    end
                end
                ISSUE: begin
                    cnt <= CW'(C_ROM_LATENCY - 1);
                end
                WAIT: begin
                    if (cnt == '0) rdata_q <= bus.rom_data;
                    else           cnt     <= cnt - CW'(1);
                end
                ACK: begin
                    // Advances even on abort so a dropped requester does
                    // not keep top priority.
                    ptr <= (grant == GW'(C_NUM_REQ - 1)) ? '0 : grant + GW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nf10_id_rom_arbiter.sv
// Testbench for nf10_id_rom_arbiter. Two instances (ROM latency 1 and 3)
// share one stimulus; a per-instance timeline model checks every output
// every cycle, while directed vectors and sequences check the named cases.
module tb_nf10_id_rom_arbiter;
    localparam int N  = 2;
    localparam int AW = 4;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req = '0;
    logic [N*AW-1:0] req_addr = '0;
    int            cyc = 0;
    int            errors = 0;
    int            checks = 0;
    logic [DW-1:0] rom [16];
    int            lat [2] = '{1, 3};

    always #5 clk = ~clk;

    nf10_id_rom_arbiter_if #(.C_NUM_REQ(N), .C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW)) bus1 ();
    nf10_id_rom_arbiter_if #(.C_NUM_REQ(N), .C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW)) bus3 ();

    assign bus1.req      = req;
    assign bus1.req_addr = req_addr;
    assign bus3.req      = req;
    assign bus3.req_addr = req_addr;

    nf10_id_rom_arbiter #(.C_NUM_REQ(N), .C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW), .C_ROM_LATENCY(1)) dut1 (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .bus           (bus1)
    );
    nf10_id_rom_arbiter #(.C_NUM_REQ(N), .C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW), .C_ROM_LATENCY(3)) dut3 (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .bus           (bus3)
    );

    // ROM models: correct word exactly L cycles after rom_en, junk otherwise.
    logic [DW-1:0] p1, p3a, p3b, p3c;
    always @(posedge clk) begin
        p1  <= bus1.rom_en ? rom[bus1.rom_addr] : {16'hBAD1, cyc[15:0]};
        p3a <= bus3.rom_en ? rom[bus3.rom_addr] : {16'hBAD3, cyc[15:0]};
        p3b <= p3a;
        p3c <= p3b;
        cyc <= cyc + 1;
    end
    assign bus1.rom_data = p1;
    assign bus3.rom_data = p3c;

    logic [N-1:0]  o_ack   [2];
    logic [DW-1:0] o_rdata [2];
    logic          o_busy  [2];
    logic          o_en    [2];
    logic [AW-1:0] o_addr  [2];
    assign o_ack[0] = bus1.ack;   assign o_ack[1] = bus3.ack;
    assign o_rdata[0] = bus1.rdata; assign o_rdata[1] = bus3.rdata;
    assign o_busy[0] = bus1.busy; assign o_busy[1] = bus3.busy;
    assign o_en[0] = bus1.rom_en; assign o_en[1] = bus3.rom_en;
    assign o_addr[0] = bus1.rom_addr; assign o_addr[1] = bus3.rom_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a service is a timeline of 3+L cycles after the
    // sampling cycle. age 1 = ROM read, age 1+L = word captured,
    // age 2+L = ack if still requested, age 3+L = dead cycle.
    bit            m_act   [2];
    int            m_age   [2];
    int            m_grant [2];
    int            m_ptr   [2];
    logic [AW-1:0] m_addr  [2];
    logic [DW-1:0] m_rdata [2];

    task automatic m_reset(input int d);
        m_act[d] = 0; m_age[d] = 0; m_grant[d] = 0; m_ptr[d] = 0;
        m_addr[d] = '0; m_rdata[d] = '0;
    endtask

    task automatic m_step(input int d);
        if (!m_act[d]) begin
            if (req != '0) begin
                for (int k = N - 1; k >= 0; k--)
                    if (req[(m_ptr[d] + k) % N]) m_grant[d] = (m_ptr[d] + k) % N;
                m_addr[d] = req_addr[m_grant[d]*AW +: AW];
                m_act[d]  = 1;
                m_age[d]  = 1;
            end
        end else begin
            if (m_age[d] == 1 + lat[d]) m_rdata[d] = rom[m_addr[d]];
            if (m_age[d] == 2 + lat[d]) m_ptr[d] = (m_grant[d] + 1) % N;
            if (m_age[d] == 3 + lat[d]) m_act[d] = 0;
            else m_age[d]++;
        end
    endtask

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) if (rst_n) m_step(d);
    end

    always @(negedge clk) begin
        logic [N-1:0] ea;
        logic         een;
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) m_reset(d);
            een = m_act[d] && (m_age[d] == 1);
            ea  = '0;
            if (m_act[d] && m_age[d] == 2 + lat[d] && req[m_grant[d]]) ea[m_grant[d]] = 1'b1;
            chk($sformatf("L%0d_ack", lat[d]), 32'(o_ack[d]), 32'(ea));
            chk($sformatf("L%0d_busy", lat[d]), 32'(o_busy[d]), 32'(m_act[d]));
            chk($sformatf("L%0d_rom_en", lat[d]), 32'(o_en[d]), 32'(een));
            chk($sformatf("L%0d_rom_addr", lat[d]), 32'(o_addr[d]), een ? 32'(m_addr[d]) : 32'd0);
            chk($sformatf("L%0d_rdata", lat[d]), o_rdata[d], m_rdata[d]);
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Waits (bounded) for an ack on instance d; returns it, its cycle and
    // the number of rom_en cycles seen meanwhile.
    task automatic wait_ack(input int d, output logic [N-1:0] a, output int c, output int ne);
        int n;
        a = '0; c = 0; ne = 0; n = 0;
        while (a == '0 && n < 40) begin
            @(negedge clk); #1;
            n++;
            ne += int'(o_en[d]);
            a = o_ack[d];
            c = cyc;
        end
        checks++;
        if (a == '0) begin
            errors++;
            $display("FAIL ack_timeout_L%0d: no ack within 40 cycles, one required", lat[d]);
        end
    endtask

    task automatic wait_en(input int d);
        int n;
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (!o_en[d] && n < 20);
        checks++;
        if (!o_en[d]) begin
            errors++;
            $display("FAIL rom_en_timeout_L%0d: no rom_en within 20 cycles", lat[d]);
        end
    endtask

    typedef struct {
        logic [N-1:0]    req;
        logic [N*AW-1:0] addr;
        logic [N-1:0]    ack;
        logic [DW-1:0]   data;
    } vec_t;
    vec_t tab [7];

    initial begin
        logic [N-1:0] a;
        int c, c1, c2, t0, ne;

        for (int i = 0; i < 16; i++) rom[i] = 32'hC0DE_0000 + 32'(i) * 32'h1111;
        rom[3] = 32'hDEAD_BEEF;
        // Each row starts from IDLE; pointer state flows from row to row.
        tab[0] = '{2'b01, {4'h0, 4'h3}, 2'b01, 32'hDEAD_BEEF};
        tab[1] = '{2'b10, {4'h5, 4'h0}, 2'b10, 32'hC0DE_5555};
        tab[2] = '{2'b11, {4'hF, 4'h0}, 2'b01, 32'hC0DE_0000};
        tab[3] = '{2'b11, {4'hF, 4'h0}, 2'b10, 32'hC0DE_FFFF};
        tab[4] = '{2'b10, {4'hA, 4'h0}, 2'b10, 32'hC0DE_AAAA};
        tab[5] = '{2'b11, {4'h0, 4'h7}, 2'b01, 32'hC0DE_7777};
        tab[6] = '{2'b10, {4'h3, 4'h9}, 2'b10, 32'hDEAD_BEEF};

        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) tick();
        chk("reset_busy", 32'(o_busy[0]), 32'd0);
        chk("reset_rdata", o_rdata[0], 32'd0);
        rst_n = 1'b1;
        tick();

        // Latency 3: ack at t+5, single rom_en pulse.
        req_addr = {4'h0, 4'h3}; req = 2'b01; t0 = cyc;
        wait_ack(1, a, c, ne);
        chk("lat3_ack", 32'(a), 32'h1);
        chk("lat3_cycle", 32'(c - t0), 32'd5);
        chk("lat3_rdata", o_rdata[1], 32'hDEAD_BEEF);
        chk("lat3_rom_en_pulses", 32'(ne), 32'd1);
        tick(); req = '0;
        repeat (12) tick();
        rst_n = 1'b0; tick(); tick(); rst_n = 1'b1; tick();

        // Directed vectors on the latency-1 instance.
        for (int r = 0; r < 7; r++) begin
            req_addr = tab[r].addr; req = tab[r].req; t0 = cyc;
            wait_ack(0, a, c, ne);
            chk($sformatf("vec%0d_ack", r), 32'(a), 32'(tab[r].ack));
            chk($sformatf("vec%0d_rdata", r), o_rdata[0], tab[r].data);
            chk($sformatf("vec%0d_latency", r), 32'(c - t0), 32'd3);
            tick(); req = '0; tick(); tick();
        end

        // Simultaneous requests, each drops after its ack.
        req_addr = {4'h5, 4'h0}; req = 2'b11;
        wait_ack(0, a, c1, ne);
        chk("sim_first_ack", 32'(a), 32'h1);
        chk("sim_first_rdata", o_rdata[0], 32'hC0DE_0000);
        tick(); req = 2'b10;
        wait_ack(0, a, c2, ne);
        chk("sim_second_ack", 32'(a), 32'h2);
        chk("sim_second_rdata", o_rdata[0], 32'hC0DE_5555);
        chk("sim_ack_gap", 32'(c2 - c1), 32'd5);
        tick(); req = '0; tick(); tick();

        // Fairness: both held for 8 services.
        req = 2'b11; c1 = cyc;
        for (int k = 0; k < 8; k++) begin
            wait_ack(0, a, c2, ne);
            chk($sformatf("fair%0d_ack", k), 32'(a), (k % 2 == 0) ? 32'h1 : 32'h2);
            if (k > 0) chk($sformatf("fair%0d_gap", k), 32'(c2 - c1), 32'd5);
            c1 = c2;
        end
        tick(); req = '0; tick(); tick();

        // Abort: req[0] drops in WAIT, comes back in RELEASE; req[1] wins next.
        req_addr = {4'h5, 4'h7}; req = 2'b11;
        wait_en(0);
        tick(); req = 2'b10;
        tick();
        @(negedge clk); #1;
        chk("abort_no_ack", 32'(o_ack[0]), 32'd0);
        chk("abort_rdata", o_rdata[0], 32'hC0DE_7777);
        tick(); req = 2'b11;
        wait_ack(0, a, c, ne);
        chk("abort_next_ack", 32'(a), 32'h2);
        chk("abort_next_rdata", o_rdata[0], 32'hC0DE_5555);
        tick(); req = '0; tick(); tick();

        // Reset during WAIT, with the pointer advanced beforehand.
        req_addr = {4'h5, 4'h3}; req = 2'b01;
        wait_ack(0, a, c, ne);
        tick(); req = '0; tick(); tick();
        req = 2'b01;
        wait_en(0);
        tick(); rst_n = 1'b0; #1;
        chk("rst_ack", 32'(o_ack[0]), 32'd0);
        chk("rst_rom_en", 32'(o_en[0]), 32'd0);
        chk("rst_busy", 32'(o_busy[0]), 32'd0);
        chk("rst_rdata", o_rdata[0], 32'd0);
        tick(); tick();
        rst_n = 1'b1; req = 2'b11; t0 = cyc;
        wait_ack(0, a, c, ne);
        chk("post_rst_ack", 32'(a), 32'h1);
        chk("post_rst_latency", 32'(c - t0), 32'd3);
        chk("post_rst_rdata", o_rdata[0], 32'hDEAD_BEEF);
        tick(); req = '0; tick(); tick();

        // Random traffic against the model, with rare resets.
        for (int k = 0; k < 2000; k++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 5) == 0) req[i] = ~req[i];
            if ($urandom_range(0, 7) == 0) req_addr = N*AW'($urandom);
            if ($urandom_range(0, 399) == 0) begin
                rst_n = 1'b0; tick(); rst_n = 1'b1;
            end
            tick();
        end
        req = '0;
        repeat (10) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
